// File: rtl/scan_ctrl_pkg.sv
// Shared types and helpers for the scan chain sequencing controller.
package scan_ctrl_pkg;

  // Controller states; encoding fixed so the state register is easy to probe.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    UPDATE = 2'd2,
    DONE   = 2'd3
  } state_e;

  // Counter width able to hold 0..w inclusive.
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/scan_shift_reg.sv
// WIDTH-bit shift register: parallel load, serial-in at MSB, serial-out at LSB.
module scan_shift_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] load_data,
  input  logic             ser_in,
  output logic [WIDTH-1:0] sh_q,
  output logic             ser_nxt_c
);

  logic [WIDTH-1:0] sh_d;

  // Load has priority over shift; otherwise hold.
  always_comb begin
    sh_d = sh_q;
    if (load) begin
      sh_d = load_data;
    end else if (shift) begin
      sh_d = {ser_in, sh_q[WIDTH-1:1]};
    end
  end

  // LSB of the next value, so the parent can register the serial output.
  assign ser_nxt_c = sh_d[0];

  // Register with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_q <= '0;
    end else begin
      sh_q <= sh_d;
    end
  end

endmodule

// File: rtl/scan_chain_ctrl.sv
// Sequencer that writes a word into a serial flop chain while capturing its
// previous contents, then strobes the shadow update and signals completion.
module scan_chain_ctrl
  import scan_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             scan_q,
  output logic             scan_en,
  output logic             scan_d,
  output logic             update_en,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] rd_data
);

  localparam int unsigned CNT_W = cnt_width(WIDTH);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             scan_en_q, scan_en_d;
  logic             scan_d_q, scan_d_d;
  logic             update_en_q, update_en_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             sh_load;
  logic             sh_shift;
  logic [WIDTH-1:0] sh_q;
  logic             sh_ser_nxt_c;

  // Shift register: loads the write word, collects the old chain contents.
  scan_shift_reg #(
    .WIDTH (WIDTH)
  ) u_shift (
    .clk       (clk),
    .rst       (rst),
    .load      (sh_load),
    .shift     (sh_shift),
    .load_data (wr_data),
    .ser_in    (scan_q),
    .sh_q      (sh_q),
    .ser_nxt_c (sh_ser_nxt_c)
  );

  // Next-state, counter, capture and registered output decode.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rd_data_d   = rd_data_q;
    sh_load     = 1'b0;
    sh_shift    = 1'b0;
    scan_en_d   = 1'b0;
    scan_d_d    = 1'b0;
    update_en_d = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          sh_load = 1'b1;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        sh_shift = 1'b1;
        cnt_d    = cnt_q + CNT_W'(1);
        // Abort beats the final shift; the chain is left partially shifted.
        if (abort) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = UPDATE;
        end
      end
      UPDATE: begin
        rd_data_d = sh_q;
        state_d   = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are decoded from the next state so they line up with state_q.
    scan_en_d   = (state_d == SHIFT);
    scan_d_d    = scan_en_d & sh_ser_nxt_c;
    update_en_d = (state_d == UPDATE);
    busy_d      = (state_d != IDLE);
    done_d      = (state_d == DONE);
  end

  // State, counter and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rd_data_q   <= '0;
      scan_en_q   <= 1'b0;
      scan_d_q    <= 1'b0;
      update_en_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rd_data_q   <= rd_data_d;
      scan_en_q   <= scan_en_d;
      scan_d_q    <= scan_d_d;
      update_en_q <= update_en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign scan_en   = scan_en_q;
  assign scan_d    = scan_d_q;
  assign update_en = update_en_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign rd_data   = rd_data_q;

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Bench for scan_chain_ctrl: an 8-flop chain plus shadow register model,
// transaction-level expectations and randomized write words.
module tb_scan_chain_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       abort;
  logic [7:0] wr_data;
  logic       scan_q;
  logic       scan_en;
  logic       scan_d;
  logic       update_en;
  logic       busy;
  logic       done;
  logic [7:0] rd_data;

  logic [7:0] chain  = 8'h00;
  logic [7:0] shadow = 8'h00;

  logic [7:0] ref_chain = 8'h00;
  logic [7:0] prev_rd   = 8'h00;

  int n_pass  = 0;
  int n_total = 0;

  scan_chain_ctrl #(
    .WIDTH (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .wr_data   (wr_data),
    .scan_q    (scan_q),
    .scan_en   (scan_en),
    .scan_d    (scan_d),
    .update_en (update_en),
    .busy      (busy),
    .done      (done),
    .rd_data   (rd_data)
  );

  always #5 clk = ~clk;

  // External flop chain and shadow bank driven by the controller strobes.
  always @(posedge clk) begin
    if (scan_en) chain <= {scan_d, chain[7:1]};
    if (update_en) shadow <= chain;
  end
  assign scan_q = chain[0];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Chain after n shifts of word w into the current chain contents.
  function automatic logic [7:0] partial_chain(input logic [7:0] old, input logic [7:0] w,
                                               input int n);
    logic [31:0] v;
    v = (32'(old) >> n) | (32'(w) << (8 - n));
    return v[7:0];
  endfunction

  // Full transaction from IDLE; optional stray start pulses in cycles pa/pb.
  task automatic do_txn(input logic [7:0] w, input int pa, input int pb, input string nm);
    logic [7:0] exp_rd;
    int dones;
    exp_rd = ref_chain;
    dones  = 0;
    start   = 1'b1;
    wr_data = w;
    @(negedge clk);
    for (int cyc = 1; cyc <= 11; cyc++) begin
      wr_data = 8'($urandom);
      start   = (cyc == pa || cyc == pb);
      chk($sformatf("%s scan_en c%0d", nm, cyc), 32'(scan_en), 32'(cyc <= 8));
      chk($sformatf("%s scan_d c%0d", nm, cyc), 32'(scan_d), (cyc <= 8) ? 32'(w[cyc-1]) : 32'd0);
      chk($sformatf("%s update_en c%0d", nm, cyc), 32'(update_en), 32'(cyc == 9));
      chk($sformatf("%s done c%0d", nm, cyc), 32'(done), 32'(cyc == 10));
      chk($sformatf("%s busy c%0d", nm, cyc), 32'(busy), 32'(cyc <= 10));
      if (done === 1'b1) dones++;
      if (cyc == 10) chk($sformatf("%s rd_data", nm), 32'(rd_data), 32'(exp_rd));
      @(negedge clk);
    end
    start = 1'b0;
    chk($sformatf("%s done count", nm), 32'(dones), 32'd1);
    chk($sformatf("%s shadow", nm), 32'(shadow), 32'(w));
    ref_chain = w;
    prev_rd   = exp_rd;
  endtask

  // Transaction aborted during SHIFT cycle n (1..8).
  task automatic do_abort(input logic [7:0] w, input int n);
    logic [7:0] shadow_before;
    shadow_before = shadow;
    start   = 1'b1;
    wr_data = w;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 1; cyc <= n; cyc++) begin
      wr_data = 8'($urandom);
      abort   = (cyc == n);
      chk($sformatf("abort%0d scan_en c%0d", n, cyc), 32'(scan_en), 32'd1);
      chk($sformatf("abort%0d busy c%0d", n, cyc), 32'(busy), 32'd1);
      @(negedge clk);
    end
    abort = 1'b0;
    for (int cyc = 1; cyc <= 6; cyc++) begin
      chk($sformatf("abort%0d idle scan_en +%0d", n, cyc), 32'(scan_en), 32'd0);
      chk($sformatf("abort%0d idle busy +%0d", n, cyc), 32'(busy), 32'd0);
      chk($sformatf("abort%0d update_en +%0d", n, cyc), 32'(update_en), 32'd0);
      chk($sformatf("abort%0d done +%0d", n, cyc), 32'(done), 32'd0);
      @(negedge clk);
    end
    ref_chain = partial_chain(ref_chain, w, n);
    chk($sformatf("abort%0d rd_data kept", n), 32'(rd_data), 32'(prev_rd));
    chk($sformatf("abort%0d chain", n), 32'(chain), 32'(ref_chain));
    chk($sformatf("abort%0d shadow kept", n), 32'(shadow), 32'(shadow_before));
  endtask

  // Asynchronous reset raised between edges in SHIFT cycle k (2..8).
  task automatic do_rst(input logic [7:0] w, input int k);
    start   = 1'b1;
    wr_data = w;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 1; cyc < k; cyc++) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk($sformatf("rst%0d scan_en", k), 32'(scan_en), 32'd0);
    chk($sformatf("rst%0d scan_d", k), 32'(scan_d), 32'd0);
    chk($sformatf("rst%0d update_en", k), 32'(update_en), 32'd0);
    chk($sformatf("rst%0d busy", k), 32'(busy), 32'd0);
    chk($sformatf("rst%0d done", k), 32'(done), 32'd0);
    chk($sformatf("rst%0d rd_data", k), 32'(rd_data), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk($sformatf("rst%0d post busy", k), 32'(busy), 32'd0);
    ref_chain = partial_chain(ref_chain, w, k - 1);
    chk($sformatf("rst%0d chain", k), 32'(chain), 32'(ref_chain));
    prev_rd = 8'h00;
  endtask

  // start held high for n back-to-back transactions.
  task automatic do_hold(input int n);
    logic [7:0] words[$];
    logic [7:0] exp_rd;
    for (int i = 0; i < n; i++) words.push_back(8'($urandom));
    start   = 1'b1;
    wr_data = words[0];
    @(negedge clk);
    for (int t = 0; t < n; t++) begin
      exp_rd = ref_chain;
      for (int cyc = 1; cyc <= 11; cyc++) begin
        if (cyc == 1) wr_data = 8'($urandom);
        if (cyc == 11) begin
          start = (t < n - 1);
          if (t < n - 1) wr_data = words[t+1];
        end
        chk($sformatf("hold t%0d done c%0d", t, cyc), 32'(done), 32'(cyc == 10));
        chk($sformatf("hold t%0d busy c%0d", t, cyc), 32'(busy), 32'(cyc <= 10));
        if (cyc == 10) chk($sformatf("hold t%0d rd_data", t), 32'(rd_data), 32'(exp_rd));
        @(negedge clk);
      end
      chk($sformatf("hold t%0d shadow", t), 32'(shadow), 32'(words[t]));
      ref_chain = words[t];
      prev_rd   = exp_rd;
    end
    start = 1'b0;
  endtask

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    abort   = 1'b0;
    wr_data = 8'h00;
    @(negedge clk);
    chk("reset scan_en", 32'(scan_en), 32'd0);
    chk("reset scan_d", 32'(scan_d), 32'd0);
    chk("reset update_en", 32'(update_en), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset rd_data", 32'(rd_data), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    do_txn(8'hA5, 0, 0, "t1");
    do_txn(8'h3C, 0, 0, "t2");
    do_txn(8'($urandom), 3, 9, "t3");
    do_abort(8'($urandom), 4);
    do_txn(8'($urandom), 0, 0, "post_abort");
    do_abort(8'($urandom), 8);
    do_abort(8'($urandom), 1);
    do_txn(8'($urandom), 0, 0, "post_abort2");
    do_rst(8'($urandom), 4);
    do_txn(8'($urandom), 0, 0, "post_rst");
    do_hold(4);
    for (int i = 0; i < 4; i++) begin
      do_txn(8'($urandom), int'($urandom_range(1, 10)), int'($urandom_range(1, 10)),
             $sformatf("rnd%0d", i));
      do_abort(8'($urandom), int'($urandom_range(1, 8)));
    end
    do_rst(8'($urandom), int'($urandom_range(2, 8)));
    do_txn(8'($urandom), 0, 0, "final");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
